qmult_seq: RTL
==============

Name: qmult_seq

Overview:
Iterative shift-and-add multiplier for the sign-magnitude Qm.n format: MSB is sign, N-1 magnitude bits, Q fractional bits. It consumes two sign-magnitude operands and produces a sign-magnitude product of the same format, with a saturation/overflow flag. It sits directly upstream of the two's-complement conversion stage, which receives its magnitude output. Uses a start/complete handshake so a full-width multiplier array is not needed.

Parameters:
Q, 15, number of fractional bits.
N, 32, total word width including sign bit.

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  request; sampled only in IDLE or DONE
i_multiplicand  input  N  sign-magnitude operand A
i_multiplier  input  N  sign-magnitude operand B
o_result  output  N  sign-magnitude product, valid while o_complete=1
o_complete  output  1  result valid, held until next accepted start
o_busy  output  1  high during RUN
o_overflow  output  1  product magnitude exceeded N-1 bits; valid with o_complete

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; o_result=0, o_complete=0, o_busy=0, o_overflow=0; accumulator and counter=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + i_start=1 on edge:
  - latch mag_a=A[N-2:0] and mag_b=B[N-2:0];
  - sign = A[N-1] xor B[N-1];
  - acc(2N-2 bits)=0, count=0;
  - o_complete=0, o_overflow=0, o_busy=1;
  - go to RUN.
- RUN, each cycle:
  - if mag_b[0]: acc += mag_a zero-extended to 2N-2 bits;
  - mag_a <<= 1 (2N-2-bit register), mag_b >>= 1, count++.
  - After N-1 RUN cycles (count==N-2 on the final one), go to DONE.
- Entering DONE:
  - o_busy=0, o_complete=1;
  - overflow = |acc[2N-3 : N-1+Q] (bits above retained window);
  - magnitude = overflow ? all ones (N-1 bits) : acc[N-2+Q : Q] (truncate toward zero, no rounding);
  - sign forced 0 when magnitude==0, so negative zero is never emitted;
  - o_result={sign,magnitude}.
- Latency: start accepted at edge 0 → o_complete=1 after edge N (N-1 RUN cycles + DONE entry). For N=32 that is 32 cycles.
- i_start while busy (RUN) is ignored; operands on inputs are not re-sampled.
- i_start in DONE restarts immediately; o_complete drops on that edge.
- Inputs need not be held after the accepting edge.
- Reset asserted mid-RUN aborts to IDLE with all outputs zero; no partial result is exposed.
- Operand magnitudes of zero still take full latency (no early exit).

Decomposition:
- Shared package qpoint_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default Q/N constants;
  - a function returning normalized sign-magnitude (zero→positive), reused by adder/divider blocks.
- No sub-module required; control FSM and datapath fit in one module.
- Optional split: qmult_seq_dp (accumulator/shift registers) under FSM control if timing at large N demands it.

Test Plan:
- Q=15,N=32: A=0x0000C000 (1.5), B=0x00010000 (2.0), start → after 32 cycles o_complete=1, o_result=0x00018000, o_overflow=0.
- A=0x8000C000 (-1.5), B=0x00010000 → o_result=0x80018000; A and B both negative → 0x00018000.
- A=0x40000000 (32768.0), B=0x00010000 (2.0) → o_overflow=1, o_result=0x7FFFFFFF; with A negative → 0xFFFFFFFF.
- A=0x80000000 (-0), B=0x00008000 (1.0) → o_result=0x00000000 (positive zero); A=0x00000001, B=0x00000001 → result 0 (truncation), o_overflow=0.
- Pulse i_start with new operands during RUN → ignored, first result unchanged at cycle 32; then start from DONE with 0x00008000×0x00008000 → o_complete drops next edge, 32 cycles later o_result=0x00008000.
- Deassert i_rst_n at cycle 10 of RUN → outputs 0 asynchronously, state IDLE; after release, new start produces correct result with full latency.

Source files
------------

// File: rtl/qpoint_pkg.sv
// rtl/qpoint_pkg.sv - shared definitions for the sign-magnitude Qm.n arithmetic blocks
package qpoint_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_Q = 15;
  localparam int DEF_N = 32;

  // A zero magnitude always carries a positive sign, so -0 never leaves a block.
  function automatic logic normalize_sign(input logic sign, input logic mag_is_zero);
    return sign & ~mag_is_zero;
  endfunction

endpackage

// File: rtl/qmult_seq.sv
// rtl/qmult_seq.sv - iterative shift-and-add sign-magnitude Qm.n multiplier
module qmult_seq
  import qpoint_pkg::*;
#(
  parameter int Q = DEF_Q,
  parameter int N = DEF_N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         o_complete,
  output logic         o_busy,
  output logic         o_overflow
);

  localparam int AW = 2*N-2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_COUNT = CW'(N-1);

  logic [1:0]    state;
  logic [AW-1:0] mag_a;
  logic [AW-1:0] acc;
  logic [N-2:0]  mag_b;
  logic [CW-1:0] count;
  logic          sign;

  logic          ovf_w;
  logic [N-2:0]  mag_w;

  always_comb begin
    ovf_w = |acc[AW-1:N-1+Q];
    mag_w = ovf_w ? {(N-1){1'b1}} : acc[N-2+Q:Q];
  end

  // Counts 0..N-2 are accumulation steps; the cycle at N-1 registers the result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      mag_a      <= '0;
      mag_b      <= '0;
      acc        <= '0;
      count      <= '0;
      sign       <= 1'b0;
      o_result   <= '0;
      o_complete <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            mag_a      <= {{(N-1){1'b0}}, i_multiplicand[N-2:0]};
            mag_b      <= i_multiplier[N-2:0];
            sign       <= i_multiplicand[N-1] ^ i_multiplier[N-1];
            acc        <= '0;
            count      <= '0;
            o_complete <= 1'b0;
            o_overflow <= 1'b0;
            o_busy     <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (count == LAST_COUNT) begin
            o_busy     <= 1'b0;
            o_complete <= 1'b1;
            o_overflow <= ovf_w;
            o_result   <= {normalize_sign(sign, mag_w == '0), mag_w};
            state      <= ST_DONE;
          end else begin
            if (mag_b[0]) begin
              acc <= acc + mag_a;
            end
            mag_a <= mag_a << 1;
            mag_b <= mag_b >> 1;
            count <= count + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
